// File: rtl/wash_disp_scan_if.sv
// wash_disp_scan_if
//   Display bus between the wash controller and the display scanner.
//   Signals:
//     d0..d3 : 4-bit digit codes (d0 rightmost, d3 leftmost)
//     dp     : decimal-point request, bit i belongs to digit i
//     blink  : per-digit blink request (only with WASH_DISP_BLINK_EN)
//     ena    : one-hot-or-zero digit enables, active-high
//     light  : segment byte, bit0..6 = a..g, bit7 = dp, active-high
//   Modports:
//     master : controller side, drives codes, receives ena/light
//     slave  : scanner side, receives codes, drives ena/light
//   Optional feature macro: WASH_DISP_BLINK_EN
interface wash_disp_scan_if;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] dp;
`ifdef WASH_DISP_BLINK_EN
  logic [3:0] blink;
`endif
  logic [3:0] ena;
  logic [7:0] light;

`ifdef WASH_DISP_BLINK_EN
  modport master (output d0, d1, d2, d3, dp, blink, input ena, light);
  modport slave  (input d0, d1, d2, d3, dp, blink, output ena, light);
`else
  modport master (output d0, d1, d2, d3, dp, input ena, light);
  modport slave  (input d0, d1, d2, d3, dp, output ena, light);
`endif
endinterface

// File: rtl/wash_disp_scan.sv
// wash_disp_scan
//   Time-multiplexed driver for the 4-digit 7-segment display of the
//   washing-machine controller. Each digit gets a slot of DIV = CLK_HZ/SLOT_HZ
//   cycles; the first BLANK_CYC cycles of every slot are dark to avoid
//   ghosting. Digit codes are snapshotted once per frame (on the slot 3->0
//   edge) so a frame never shows a mix of old and new values.
//   Ports:
//     clk : system clock
//     rst : synchronous active-high reset
//     bus : wash_disp_scan_if.slave (d0..d3, dp, [blink] in; ena, light out)
//   Optional feature macro: WASH_DISP_BLINK_EN
//     Adds per-digit blink: a frame counter toggles a phase bit every
//     BLINK_FRAMES frames; while phase=1, digits with blink set stay dark.
module wash_disp_scan #(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned SLOT_HZ      = 1000,
  parameter int unsigned BLANK_CYC    = 2000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic           clk,
  input  logic           rst,
  wash_disp_scan_if.slave bus
);

  localparam int unsigned DIV = CLK_HZ / SLOT_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

  localparam logic [3:0] CODE_BLANK = 4'd11;

  // Reject configurations the slot arithmetic cannot honour.
  if (DIV < 2 || BLANK_CYC >= DIV || BLINK_FRAMES < 1) begin : g_bad_cfg
    $error("wash_disp_scan: need DIV >= 2, BLANK_CYC < DIV, BLINK_FRAMES >= 1");
  end

  function automatic logic [7:0] seg_of(input logic [3:0] code, input logic dp_bit);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      4'd10:   s = 7'h40;
      default: s = 7'h00;
    endcase
    return {dp_bit, s};
  endfunction

  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic [3:0]    code [4];
  logic [3:0]    sdp;
  logic          slot_end;
  logic          frame_end;
  logic          dark;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (slot == 2'd3);

`ifdef WASH_DISP_BLINK_EN
  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  logic [3:0]    sblink;
  logic [FW-1:0] fcnt;
  logic          phase;

  assign dark = phase && sblink[slot];

  always_ff @(posedge clk) begin
    if (rst) begin
      sblink <= '0;
      fcnt   <= '0;
      phase  <= 1'b0;
    end else if (frame_end) begin
      sblink <= bus.blink;
      if (fcnt == FCNT_LAST) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end
`else
  assign dark = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      slot      <= '0;
      sdp       <= '0;
      bus.ena   <= '0;
      bus.light <= '0;
      for (int unsigned i = 0; i < 4; i++) code[i] <= CODE_BLANK;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) slot <= slot + 2'd1;

      if (frame_end) begin
        code[0] <= bus.d0;
        code[1] <= bus.d1;
        code[2] <= bus.d2;
        code[3] <= bus.d3;
        sdp     <= bus.dp;
      end

      // Outputs reflect the (slot, cnt) state seen at this edge and the
      // shadow contents before any snapshot taken on the same edge.
      if (cnt < BLANK_LIM || dark) begin
        bus.ena   <= '0;
        bus.light <= '0;
      end else begin
        bus.ena   <= 4'b0001 << slot;
        bus.light <= seg_of(code[slot], sdp[slot]);
      end
    end
  end

endmodule

// File: tb/tb_wash_disp_scan.sv
// tb_wash_disp_scan
//   Randomized and directed stimulus against a cycle-index reference model:
//   the expected output after each edge is derived from the number of edges
//   since reset (slot = position/DIV, cnt = position%DIV, frame = edges/FRAME)
//   and the inputs latched at the last frame boundary.
//   Optional feature macro: WASH_DISP_BLINK_EN
module tb_wash_disp_scan;
  localparam int unsigned CLK_HZ       = 1000;
  localparam int unsigned SLOT_HZ      = 100;
  localparam int unsigned BLANK_CYC    = 2;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int unsigned DIV          = CLK_HZ / SLOT_HZ;
  localparam int unsigned FRAME        = 4 * DIV;

  localparam logic [7:0] SEG [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  logic clk = 1'b0;
  logic rst = 1'b1;

  wash_disp_scan_if bus ();

  wash_disp_scan #(
    .CLK_HZ      (CLK_HZ),
    .SLOT_HZ     (SLOT_HZ),
    .BLANK_CYC   (BLANK_CYC),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned n_edges = 0;
  logic [3:0]  m_code [4];
  logic [3:0]  m_dp;
  logic [3:0]  m_blink;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (edge %0d, t=%0t)", tag, got, exp, n_edges, $time);
    end
  endtask

  // One clock edge: predict, then compare #1 later.
  task automatic step();
    logic [3:0]  e_ena;
    logic [7:0]  e_light;
    int unsigned pos, sl, c, f;
    @(posedge clk);
    e_ena   = '0;
    e_light = '0;
    if (rst) begin
      n_edges = 0;
      for (int i = 0; i < 4; i++) m_code[i] = 4'd11;
      m_dp    = '0;
      m_blink = '0;
    end else begin
      pos = n_edges % FRAME;
      sl  = pos / DIV;
      c   = pos % DIV;
      f   = n_edges / FRAME;
      if (c >= BLANK_CYC) begin
        e_ena   = 4'(1 << sl);
        e_light = SEG[m_code[sl]] | (m_dp[sl] ? 8'h80 : 8'h00);
        if ((f / BLINK_FRAMES) % 2 == 1 && m_blink[sl]) begin
          e_ena   = '0;
          e_light = '0;
        end
      end
      n_edges++;
      if (pos == FRAME - 1) begin
        m_code[0] = bus.d0;
        m_code[1] = bus.d1;
        m_code[2] = bus.d2;
        m_code[3] = bus.d3;
        m_dp      = bus.dp;
`ifdef WASH_DISP_BLINK_EN
        m_blink   = bus.blink;
`endif
      end
    end
    #1;
    check("ena", {4'b0, bus.ena}, {4'b0, e_ena});
    check("light", bus.light, e_light);
  endtask

  task automatic run(input int unsigned cycles);
    repeat (cycles) step();
  endtask

  // Advance until the next edge sees frame position 'pos' (bounded).
  task automatic run_to(input int unsigned pos);
    for (int unsigned k = 0; k < FRAME && (n_edges % FRAME) != pos; k++) step();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_code[i] = 4'd11;
    m_dp    = '0;
    m_blink = '0;
    bus.d0 = 4'd0;
    bus.d1 = 4'd11;
    bus.d2 = 4'd9;
    bus.d3 = 4'd9;
    bus.dp = 4'b0000;
`ifdef WASH_DISP_BLINK_EN
    bus.blink = 4'b0000;
`endif

    // Reset, then a blank first frame followed by 0 / blank / 9 / 9.
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(2 * FRAME);

    // Mid-frame change must wait for the next snapshot.
    bus.d0 = 4'd5;
    run(2 * FRAME);
    run(15);
    bus.d0 = 4'd7;
    run(2 * FRAME);

    // Minus sign with dp, blank code without dp.
    bus.dp = 4'b0010;
    bus.d1 = 4'd10;
    bus.d0 = 4'd12;
    run(2 * FRAME);

    // Change present exactly at the snapshot edge is captured.
    run_to(FRAME - 1);
    bus.d2 = 4'd3;
    bus.dp = 4'b0101;
    run(2 * FRAME);

    // Reset while slot 2, cnt 5.
    run_to(2 * DIV + 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.d0 = 4'd8;
    run(2 * FRAME);

`ifdef WASH_DISP_BLINK_EN
    bus.blink = 4'b0001;
    run(8 * FRAME);
    bus.blink = 4'b0000;
`endif

    // Randomized traffic with occasional resets.
    repeat (4000) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.d0 = 4'($urandom);
        bus.d1 = 4'($urandom);
        bus.d2 = 4'($urandom);
        bus.d3 = 4'($urandom);
        bus.dp = 4'($urandom);
`ifdef WASH_DISP_BLINK_EN
        bus.blink = 4'($urandom);
`endif
      end
      rst = ($urandom_range(0, 699) == 0);
      step();
    end
    rst = 1'b0;
    run(FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
